// File: rtl/scroll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scroll_pkg                                                   |
// | Description : Shared lane geometry, register codes and sequencer states   |
// |               for the lane sequencer in front of the scrolling core.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package scroll_pkg;

  localparam int LANE_COUNT  = 8;
  localparam int LANE_WIDTH  = 2;
  localparam int ROW_WIDTH   = LANE_COUNT * LANE_WIDTH;
  localparam int CORE_ADDR_W = 14;

  // Register codes inside the scrolling core
  localparam logic [1:0] CORE_LANE = 2'd0;
  localparam logic [1:0] CORE_DVSR = 2'd1;
  localparam logic [1:0] CORE_BYPS = 2'd2;
  localparam logic [1:0] CORE_DOWN = 2'd3;

  // Register codes on the CPU side of the sequencer
  localparam logic [2:0] REG_ROW  = 3'd0;
  localparam logic [2:0] REG_DVSR = 3'd1;
  localparam logic [2:0] REG_BYPS = 3'd2;
  localparam logic [2:0] REG_DOWN = 3'd3;
  localparam logic [2:0] REG_CTRL = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;

  // Bit positions inside the ctrl register
  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_CLR_BIT   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2
  } seq_state_t;

  // Core bus address for a given core register code
  function automatic logic [CORE_ADDR_W-1:0] core_addr_of(input logic [1:0] code);
    return {{(CORE_ADDR_W-2){1'b0}}, code};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_row_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lane_row_fifo                                                |
// | Description : Synchronous first-word-fall-through FIFO holding lane rows. |
// |               Flush empties it and beats any coincident push or pop.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lane_row_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push+pop is legal when full
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Row storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/lane_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lane_seq_ctrl                                                |
// | Description : Pops one lane row every DVSR frames and writes it to the    |
// |               scrolling core; forwards CPU config writes with priority.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lane_seq_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int DVSR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [13:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        core_cs,
  output logic        core_write,
  output logic [13:0] core_addr,
  output logic [31:0] core_wr_data
);

  import scroll_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------- CPU decode ----------------
  logic [2:0] code;
  logic       wr_en, row_push, ctrl_wr, flush, clr_flags;
  logic       fwd_wr;
  logic [1:0] fwd_code;
  logic       unused_addr;

  assign code        = addr[2:0];
  assign unused_addr = ^addr[13:3];
  assign wr_en       = cs & write;
  assign row_push    = wr_en && (code == REG_ROW);
  assign ctrl_wr     = wr_en && (code == REG_CTRL);
  assign flush       = ctrl_wr && wr_data[CTRL_FLUSH_BIT];
  assign clr_flags   = ctrl_wr && wr_data[CTRL_CLR_BIT];

  // Map CPU config codes onto the core register they are forwarded to
  always_comb begin
    fwd_wr   = 1'b0;
    fwd_code = CORE_LANE;
    if (wr_en) begin
      case (code)
        REG_DVSR: begin fwd_wr = 1'b1; fwd_code = CORE_DVSR; end
        REG_BYPS: begin fwd_wr = 1'b1; fwd_code = CORE_BYPS; end
        REG_DOWN: begin fwd_wr = 1'b1; fwd_code = CORE_DOWN; end
        default:  ;
      endcase
    end
  end

  // ---------------- Registers ----------------
  seq_state_t            state_q, state_d;
  logic                  run_q, run_d;
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DVSR_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                  origin_q, origin_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic                  overflow_q, overflow_d;
  logic                  underrun_q, underrun_d;
  logic                  core_cs_q, core_cs_d;
  logic                  core_write_q, core_write_d;
  logic [13:0]           core_addr_q, core_addr_d;
  logic [31:0]           core_wr_data_q, core_wr_data_d;

  assign run_d  = ctrl_wr ? wr_data[CTRL_RUN_BIT] : run_q;
  assign dvsr_d = (wr_en && (code == REG_DVSR)) ? wr_data[DVSR_WIDTH-1:0] : dvsr_q;

  // ---------------- Row FIFO ----------------
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ROW_WIDTH-1:0] fifo_rd_data;

  lane_row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROW_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (row_push),
    .pop     (fifo_pop),
    .flush   (flush),
    .wr_data (wr_data[ROW_WIDTH-1:0]),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---------------- Frame tick and divider ----------------
  logic                  at_origin, tick, advance;
  logic [DVSR_WIDTH-1:0] dvsr_limit;

  assign at_origin  = (x == '0) && (y == '0);
  assign origin_d   = at_origin;
  assign tick       = at_origin && !origin_q;
  assign dvsr_limit = (dvsr_q == '0) ? '0 : dvsr_q - DVSR_WIDTH'(1);

  // Count frame ticks while running; >= keeps a shrunk divider from overrunning
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    advance     = 1'b0;
    if (!run_q) begin
      frame_cnt_d = '0;
    end else if (tick) begin
      if (frame_cnt_q >= dvsr_limit) begin
        advance     = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + DVSR_WIDTH'(1);
      end
    end
  end

  // ---------------- Sequencer and core bus arbitration ----------------
  logic underrun_set, overflow_set, grant;

  // Next sequencer state and core bus; a forward always wins the bus
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    fifo_pop       = 1'b0;
    underrun_set   = 1'b0;
    grant          = 1'b0;
    core_cs_d      = 1'b0;
    core_write_d   = 1'b0;
    core_addr_d    = '0;
    core_wr_data_d = '0;

    if (fwd_wr) begin
      core_cs_d      = 1'b1;
      core_write_d   = 1'b1;
      core_addr_d    = core_addr_of(fwd_code);
      core_wr_data_d = wr_data;
    end else if (run_q && (state_q == REQ)) begin
      grant          = 1'b1;
      core_cs_d      = 1'b1;
      core_write_d   = 1'b1;
      core_addr_d    = core_addr_of(CORE_LANE);
      core_wr_data_d = {{(32-ROW_WIDTH){1'b0}}, row_q};
    end

    if (!run_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (advance) begin
            fifo_pop     = !fifo_empty;
            row_d        = fifo_empty ? '0 : fifo_rd_data;
            underrun_set = fifo_empty;
            state_d      = REQ;
          end
        end
        REQ:     if (grant) state_d = WAIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear survives
  assign overflow_set = row_push && fifo_full && !fifo_pop && !flush;
  assign overflow_d   = (overflow_q && !clr_flags) || overflow_set;
  assign underrun_d   = (underrun_q && !clr_flags) || underrun_set;

  // State, configuration, flags and the registered core bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      run_q          <= 1'b0;
      dvsr_q         <= '0;
      frame_cnt_q    <= '0;
      origin_q       <= 1'b0;
      row_q          <= '0;
      overflow_q     <= 1'b0;
      underrun_q     <= 1'b0;
      core_cs_q      <= 1'b0;
      core_write_q   <= 1'b0;
      core_addr_q    <= '0;
      core_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      dvsr_q         <= dvsr_d;
      frame_cnt_q    <= frame_cnt_d;
      origin_q       <= origin_d;
      row_q          <= row_d;
      overflow_q     <= overflow_d;
      underrun_q     <= underrun_d;
      core_cs_q      <= core_cs_d;
      core_write_q   <= core_write_d;
      core_addr_q    <= core_addr_d;
      core_wr_data_q <= core_wr_data_d;
    end
  end

  assign core_cs      = core_cs_q;
  assign core_write   = core_write_q;
  assign core_addr    = core_addr_q;
  assign core_wr_data = core_wr_data_q;

  // ---------------- Status read ----------------
  logic [4:0]  count5;
  logic [31:0] status;

  assign count5  = 5'(fifo_count);
  assign status  = {19'd0, run_q, underrun_q, overflow_q, fifo_full, fifo_empty, 3'd0, count5};
  assign rd_data = (cs && read && (code == REG_STAT)) ? status : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_lane_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lane_seq_ctrl                                             |
// | Description : Self-checking bench for lane_seq_ctrl with directed cases   |
// |               and a randomized run against a queue-based row model.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_lane_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        cs, write, read;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic        core_cs, core_write;
  logic [13:0] core_addr;
  logic [31:0] core_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t obs[$];

  lane_seq_ctrl #(.FIFO_DEPTH(16), .DVSR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .core_cs(core_cs),
    .core_write(core_write), .core_addr(core_addr), .core_wr_data(core_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every core write seen on the bus
  always @(negedge clk)
    if (core_cs === 1'b1 && core_write === 1'b1) obs.push_back('{cyc, core_addr, core_wr_data});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic logic [45:0] obs_at(int i);
    if (i < obs.size()) return {obs[i].addr, obs[i].data};
    return '1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] code, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = {11'd0, code}; wr_data = d;
    step(1);
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic read_status(output logic [31:0] s);
    cs = 1'b1; read = 1'b1; addr = 14'd5;
    #1 s = rd_data;
    cs = 1'b0; read = 1'b0; addr = '0;
  endtask

  // One frame: origin held for `hold` cycles, then a long stretch away from it
  task automatic frame(input int hold);
    x = 11'd0; y = 11'd0;
    step(hold);
    x = 11'd7; y = 11'd2;
    step(8);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    logic [31:0] s;
    apply_reset();
    checks++; if ({core_cs, core_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {core_cs, core_write}); end
    checks++; if (core_addr !== 14'd0) begin errors++; $display("FAIL reset_core_addr got %h want 0", core_addr); end
    checks++; if (core_wr_data !== 32'd0) begin errors++; $display("FAIL reset_core_data got %h want 0", core_wr_data); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_idle got %h want 0", rd_data); end
    read_status(s);
    checks++; if (s !== 32'h0000_0100) begin errors++; $display("FAIL reset_status got %h want 00000100", s); end
  endtask

  task automatic test_two_rows();
    logic [31:0] s;
    cpu_wr(3'd1, 32'd2);
    step(1);
    checks++; if (obs_at(0) !== {14'd1, 32'd2}) begin errors++; $display("FAIL dvsr_forward got %h want %h", obs_at(0), {14'd1, 32'd2}); end
    obs.delete();
    cpu_wr(3'd4, 32'd1);
    step(3);
    cpu_wr(3'd0, 32'h1B1B);
    cpu_wr(3'd0, 32'hE4E4);
    read_status(s);
    checks++; if (s !== 32'h0000_1002) begin errors++; $display("FAIL two_rows_status got %h want 00001002", s); end
    for (int k = 1; k <= 4; k++) begin
      frame(1);
      checks++; if (obs.size() !== k / 2) begin errors++; $display("FAIL two_rows_count tick %0d got %0d want %0d", k, obs.size(), k / 2); end
    end
    checks++; if (obs_at(0) !== {14'd0, 32'h1B1B}) begin errors++; $display("FAIL two_rows_first got %h want %h", obs_at(0), {14'd0, 32'h1B1B}); end
    checks++; if (obs_at(1) !== {14'd0, 32'hE4E4}) begin errors++; $display("FAIL two_rows_second got %h want %h", obs_at(1), {14'd0, 32'hE4E4}); end
  endtask

  task automatic test_underrun();
    logic [31:0] s;
    cpu_wr(3'd1, 32'd1);
    step(1);
    obs.delete();
    frame(1);
    checks++; if (obs.size() !== 1) begin errors++; $display("FAIL underrun_count got %0d want 1", obs.size()); end
    checks++; if (obs_at(0) !== 46'd0) begin errors++; $display("FAIL underrun_data got %h want 0", obs_at(0)); end
    read_status(s);
    checks++; if (s !== 32'h0000_1900) begin errors++; $display("FAIL underrun_flag got %h want 00001900", s); end
    step(1);
    cpu_wr(3'd4, 32'd5);
    read_status(s);
    checks++; if (s !== 32'h0000_1100) begin errors++; $display("FAIL underrun_clear got %h want 00001100", s); end
    step(1);
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    logic [15:0] rows [17];
    cpu_wr(3'd4, 32'd6);
    step(2);
    for (int i = 0; i < 17; i++) begin
      rows[i] = 16'($urandom);
      cpu_wr(3'd0, {16'($urandom), rows[i]});
    end
    read_status(s);
    checks++; if (s[4:0] !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", s[4:0]); end
    checks++; if (s[9] !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", s[9]); end
    checks++; if (s[10] !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", s[10]); end
    step(1);
    cpu_wr(3'd4, 32'd1);
    step(3);
    obs.delete();
    repeat (17) frame(1);
    checks++; if (obs.size() !== 17) begin errors++; $display("FAIL ovf_writes got %0d want 17", obs.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (obs_at(i) !== {14'd0, 16'd0, rows[i]}) begin errors++; $display("FAIL ovf_row%0d got %h want %h", i, obs_at(i), {14'd0, 16'd0, rows[i]}); end
    end
    checks++; if (obs_at(16) !== 46'd0) begin errors++; $display("FAIL ovf_row17_dropped got %h want 0", obs_at(16)); end
    cpu_wr(3'd4, 32'd5);
    step(1);
  endtask

  task automatic test_tick_hold();
    cpu_wr(3'd1, 32'd0);
    step(1);
    cpu_wr(3'd0, 32'h0000_A5C3);
    cpu_wr(3'd0, 32'h0000_3C5A);
    obs.delete();
    frame(4);
    checks++; if (obs.size() !== 1) begin errors++; $display("FAIL hold_one_tick got %0d want 1", obs.size()); end
    checks++; if (obs_at(0) !== {14'd0, 32'h0000_A5C3}) begin errors++; $display("FAIL hold_row_a got %h want %h", obs_at(0), {14'd0, 32'h0000_A5C3}); end
    frame(4);
    checks++; if (obs.size() !== 2) begin errors++; $display("FAIL hold_dvsr0_every_frame got %0d want 2", obs.size()); end
    checks++; if (obs_at(1) !== {14'd0, 32'h0000_3C5A}) begin errors++; $display("FAIL hold_row_b got %h want %h", obs_at(1), {14'd0, 32'h0000_3C5A}); end
  endtask

  task automatic test_arbitration();
    int d;
    cpu_wr(3'd0, 32'h0000_7E81);
    obs.delete();
    x = 11'd0; y = 11'd0;
    step(1);
    cpu_wr(3'd2, 32'hCAFE_0102);
    x = 11'd7; y = 11'd2;
    step(8);
    checks++; if (obs.size() !== 2) begin errors++; $display("FAIL arb_count got %0d want 2", obs.size()); end
    checks++; if (obs_at(0) !== {14'd2, 32'hCAFE_0102}) begin errors++; $display("FAIL arb_bypass_first got %h want %h", obs_at(0), {14'd2, 32'hCAFE_0102}); end
    checks++; if (obs_at(1) !== {14'd0, 32'h0000_7E81}) begin errors++; $display("FAIL arb_lane_second got %h want %h", obs_at(1), {14'd0, 32'h0000_7E81}); end
    d = (obs.size() >= 2) ? obs[1].cyc - obs[0].cyc : -1;
    checks++; if (d !== 1) begin errors++; $display("FAIL arb_gap got %0d want 1", d); end
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] s;
    cpu_wr(3'd0, 32'h0000_1111);
    cpu_wr(3'd0, 32'h0000_2222);
    obs.delete();
    x = 11'd0; y = 11'd0;
    step(1);
    reset = 1'b1;
    #1;
    checks++; if ({core_cs, core_write, core_addr, core_wr_data} !== 48'd0) begin errors++; $display("FAIL rst_req_core got %h want 0", {core_cs, core_write, core_addr, core_wr_data}); end
    step(2);
    x = 11'd7; y = 11'd2;
    reset = 1'b0;
    step(1);
    read_status(s);
    checks++; if (s !== 32'h0000_0100) begin errors++; $display("FAIL rst_req_status got %h want 00000100", s); end
    step(1);
    repeat (3) frame(1);
    checks++; if (obs.size() !== 0) begin errors++; $display("FAIL rst_req_no_write got %0d want 0", obs.size()); end
  endtask

  // Randomized traffic against a queue model of the row FIFO and frame divider
  task automatic test_random();
    logic [15:0] mq[$];
    logic [31:0] exp_lane[$];
    logic [45:0] exp_fwd[$];
    logic [31:0] got_lane[$];
    logic [45:0] got_fwd[$];
    logic [31:0] s, want, r;
    int mdvsr, mcnt, lim, op, n;
    bit movf, mund;
    apply_reset();
    obs.delete();
    mcnt = 0; movf = 0; mund = 0;
    mdvsr = $urandom_range(0, 3);
    cpu_wr(3'd1, 32'(mdvsr));
    exp_fwd.push_back({14'd1, 32'(mdvsr)});
    cpu_wr(3'd4, 32'd1);
    step(3);
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        r = $urandom;
        cpu_wr(3'd0, r);
        if (mq.size() < 16) mq.push_back(r[15:0]); else movf = 1;
      end else if (op <= 6) begin
        frame($urandom_range(1, 3));
        lim = (mdvsr == 0) ? 0 : mdvsr - 1;
        if (mcnt == lim) begin
          mcnt = 0;
          if (mq.size() > 0) exp_lane.push_back({16'd0, mq.pop_front()});
          else begin exp_lane.push_back(32'd0); mund = 1; end
        end else mcnt++;
      end else if (op == 7) begin
        if (mcnt == 0) begin
          mdvsr = $urandom_range(0, 3);
          cpu_wr(3'd1, 32'(mdvsr));
          exp_fwd.push_back({14'd1, 32'(mdvsr)});
        end else begin
          r = $urandom;
          n = $urandom_range(2, 3);
          cpu_wr(3'(n), r);
          exp_fwd.push_back({14'(n), r});
        end
      end else if (op == 8) begin
        cpu_wr(3'd4, 32'd7);
        mq.delete(); movf = 0; mund = 0;
      end else begin
        read_status(s);
        want = {19'd0, 1'b1, mund, movf, (mq.size() == 16), (mq.size() == 0), 3'd0, 5'(mq.size())};
        checks++; if (s !== want) begin errors++; $display("FAIL rand_status it %0d got %h want %h", it, s, want); end
        step(1);
      end
    end
    step(4);
    foreach (obs[i]) begin
      if (obs[i].addr == 14'd0) got_lane.push_back(obs[i].data);
      else got_fwd.push_back({obs[i].addr, obs[i].data});
    end
    checks++; if (got_lane.size() !== exp_lane.size()) begin errors++; $display("FAIL rand_lane_count got %0d want %0d", got_lane.size(), exp_lane.size()); end
    checks++; if (got_fwd.size() !== exp_fwd.size()) begin errors++; $display("FAIL rand_fwd_count got %0d want %0d", got_fwd.size(), exp_fwd.size()); end
    for (int i = 0; i < exp_lane.size() && i < got_lane.size(); i++) begin
      checks++; if (got_lane[i] !== exp_lane[i]) begin errors++; $display("FAIL rand_lane%0d got %h want %h", i, got_lane[i], exp_lane[i]); end
    end
    for (int i = 0; i < exp_fwd.size() && i < got_fwd.size(); i++) begin
      checks++; if (got_fwd[i] !== exp_fwd[i]) begin errors++; $display("FAIL rand_fwd%0d got %h want %h", i, got_fwd[i], exp_fwd[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    x = 11'd7; y = 11'd2;
    cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0; wr_data = '0;
    test_reset();
    test_two_rows();
    test_underrun();
    test_overflow();
    test_tick_hold();
    test_arbitration();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
